// File: rtl/lcd_capture_analyzer.sv
// Logic-analyzer capture core: masked trigger compare (level or rising edge),
// circular sample buffer with programmable pre-trigger depth, and an
// oldest-first synchronous read port for the frozen capture.
module lcd_capture_analyzer #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned TRIG_W = 21,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK_PIX,
    input  logic              RST,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic              trig_mode_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_pos_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pre_q, pre_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   trig_pos_q, trig_pos_d;
    logic                match_d_q;
    logic                done_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                match_c;
    logic                hit_c;
    logic                wr_en_c;
    logic [ADDR_W-1:0]   post_c;
    logic [ADDR_W-1:0]   rd_idx_c;

    // Trigger compare; edge mode needs the previous-cycle match
    assign match_c  = ((trig_i ^ trig_value_i) & trig_mask_i) == '0;
    assign hit_c    = match_c & (~mode_q | ~match_d_q);
    assign wr_en_c  = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign post_c   = ADDR_W'(DEPTH - 1) - pre_q;
    // Oldest sample sits pre slots before the trigger sample
    assign rd_idx_c = trig_pos_q - pre_q + rd_addr_i;

    // Next-state and capture bookkeeping
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        mode_d     = mode_q;
        trig_pos_d = trig_pos_q;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_i) begin
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    pre_d    = pretrig_i;
                    mode_d   = trig_mode_i;
                    state_d  = (pretrig_i == '0) ? ST_ARMED : ST_PRE;
                end
            end
            ST_PRE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == pre_q - ADDR_W'(1)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hit_c) begin
                    trig_pos_d = wr_ptr_q;
                    cnt_d      = '0;
                    state_d    = (post_c == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == post_c - ADDR_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a simultaneous arm
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    // Control registers
    always_ff @(posedge CLK_PIX or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            mode_q     <= 1'b0;
            trig_pos_q <= '0;
            match_d_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            mode_q     <= mode_d;
            trig_pos_q <= trig_pos_d;
            match_d_q  <= match_c;
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Sample buffer write port; contents survive reset
    always_ff @(posedge CLK_PIX) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Registered read port
    always_ff @(posedge CLK_PIX or posedge RST) begin
        if (RST) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_idx_c];
        end
    end

    assign rd_data_o  = rd_data_q;
    assign state_o    = state_q;
    assign done_o     = done_q;
    assign trig_pos_o = trig_pos_q;

endmodule

// File: doc/lcd_capture_analyzer.md
# lcd_capture_analyzer

- On-chip logic-analyzer capture core for the LCD pixel pipeline. It replaces the fixed JTAG analyzer instance with a parametrised capture engine that can be read from user logic.
- Watches a trigger bus (e.g. `horizontal`/`vertical`) against a masked compare value, in level or rising-edge mode.
- Records a data bus (e.g. `font_addr`/`font_data`/counters) into a circular buffer with a programmable pre-trigger depth.
- Exposes the finished capture oldest-first through a synchronous read port.

## Interface
- `DATA_W`, 40: captured data width.
- `TRIG_W`, 21: trigger bus width.
- `DEPTH`, 256: buffer depth in samples; power of two, ≥4.
- `ADDR_W`, log2(DEPTH): pointer/address width.

Ports:
- `CLK_PIX` in 1: pixel clock; the only clock.
- `RST` in 1: asynchronous, active-high reset.
- `arm_i` in 1: start-capture pulse.
- `abort_i` in 1: return to IDLE.
- `pretrig_i` in ADDR_W: pre-trigger sample count; latched on arm.
- `trig_mode_i` in 1: 0 = level match, 1 = rising edge of match; latched on arm.
- `trig_i` in TRIG_W: trigger bus.
- `trig_value_i` in TRIG_W: compare value.
- `trig_mask_i` in TRIG_W: 1 = bit participates in the compare.
- `data_i` in DATA_W: sampled data.
- `rd_addr_i` in ADDR_W: read index; 0 = oldest sample.
- `rd_data_o` out DATA_W: registered read data.
- `state_o` out 3: IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.
- `done_o` out 1: high in DONE.
- `trig_pos_o` out ADDR_W: physical buffer slot of the trigger sample.

## Operation
- **Match:** `match = ((trig_i ^ trig_value_i) & trig_mask_i) == 0`.
- **`match_d`:** registered copy of `match`, updated every cycle in every state.
- **Hit:**
  - level mode: `hit = match`;
  - edge mode: `hit = match & ~match_d`.
- **Sample write:** in PRE, ARMED and POST, every cycle writes `mem[wr_ptr] <= data_i`, then `wr_ptr <= wr_ptr+1`, wrapping mod DEPTH.
- **Derived lengths:** `pre` = latched `pretrig_i`; `post = DEPTH-1-pre`.
- **IDLE / DONE:**
  - `arm_i` → `wr_ptr=0`, `cnt=0`, latch `pre` and mode;
  - next state is ARMED if `pre==0`, else PRE.
- **PRE:**
  - `cnt++` per sample;
  - when `cnt==pre-1` → ARMED;
  - hits are ignored in PRE.
- **ARMED:**
  - on `hit`: the sample written this cycle is the trigger sample;
  - `trig_pos <= wr_ptr`, `cnt <= 0`;
  - → POST, or → DONE directly if `post==0`.
- **POST:**
  - `cnt++` per sample;
  - when `cnt==post-1` → DONE;
  - total stored is exactly DEPTH samples: `pre` before the trigger, the trigger sample, then `post` after it.
- **DONE:** no writes; buffer frozen until the next `arm_i`.
- **Readout:** `rd_data_o <= mem[(trig_pos - pre + rd_addr_i) mod DEPTH]` every cycle in any state. It is meaningful in DONE only; `rd_addr_i == pre` returns the trigger sample.
- **Precedence:**
  - `abort_i` in any state → IDLE; `trig_pos_o` and buffer contents are kept.
  - `abort_i` and `arm_i` in the same cycle → abort wins.
  - `arm_i` in PRE/ARMED/POST is ignored.
- **Mask edge case:** `trig_mask_i == 0` means match is always true. In level mode the trigger fires on the first ARMED cycle.
- **Reset:** state IDLE, `wr_ptr=0`, `cnt=0`, `trig_pos_o=0`, `match_d=0`, `rd_data_o=0`, `done_o=0`. Memory is not cleared.

## Timing
- `arm_i` sampled high at edge N → first sample written at edge N+1 (`data_i` present during cycle N+1).
- `state_o` shows PRE/ARMED after edge N.
- Trigger is evaluated on the same cycle as the sample it tags; no pipeline delay between `trig_i` and `data_i`.
- Edge mode needs `match_d`: a match already true when arming fires only if `match_d` was 0 on the previous cycle.
- DONE is entered at the edge that writes the last post sample; `done_o` is high from the following cycle.
- Read latency is 1 cycle: `rd_addr_i` at edge K → `rd_data_o` valid after edge K.
- `RST` is asserted asynchronously and released synchronously to `CLK_PIX` by the parent.
- Reset mid-capture → IDLE immediately; no further writes.

## Test plan
- **Pre-trigger capture:** DEPTH=16, `pretrig=4`, `data_i` = free-running counter, trigger `trig_i==9` (full mask), level mode.
  - Expected: DONE after 16 written samples; reads 0..15 return 5..20.
  - `rd_addr=4` returns 9; `trig_pos_o == (9 - first counter value written) mod 16`.
- **Immediate trigger:** `pretrig=0`, mask 0.
  - Expected: trigger on first sample; reads 0..15 are the 16 consecutive samples starting at arm+1; PRE state never appears.
- **Edge mode:** `trig_i` held matching through the arm.
  - Expected: no trigger.
  - Deassert for 1 cycle, reassert → trigger on the reassert cycle; read index `pre` holds that cycle's data.
- **Maximum pre-trigger:** `pretrig=DEPTH-1`.
  - Expected: DONE on the trigger cycle itself; last read index holds the trigger sample.
- **Abort/arm precedence:** abort in POST → IDLE next cycle.
  - Simultaneous arm and abort in DONE → IDLE.
  - Re-arm from IDLE → full new capture.
- **Reset mid-capture:** `RST` pulse in ARMED.
  - Expected: all outputs at reset values within the same cycle; no DONE without a new arm.
